user_cnn_seq: RTL

USER_CNN_SEQ -- requirements
Module: user_cnn_seq

---
 rtl/user_cnn_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/user_cnn_seq.sv
// CNN layer sequencer: a small register file on an OBI-style bus that steps
// the CNN engine through NUM layer descriptors, guarded by a per-layer watchdog.
module user_cnn_seq #(
    parameter int NumLayers     = 4,
    parameter int TimeoutCycles = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        cnn_start_o,
    output logic        cnn_abort_o,
    output logic [31:0] cnn_cfg_o,
    output logic [2:0]  cnn_layer_o,
    input  logic        cnn_done_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_e;

    localparam int             WdW    = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    state_e         state_q, state_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           irq_en_q, irq_en_d;
    logic [3:0]     num_q, num_d;
    logic [31:0]    cfg_q [NumLayers];
    logic [31:0]    cfg_d [NumLayers];
    logic [2:0]     layer_q, layer_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           start_q, start_d;
    logic           abort_q, abort_d;
    logic           rvalid_q, rvalid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [31:0]    rdata_q, rdata_d;

    // Address decode: only the low byte selects a register.
    logic [7:0] offs, cfg_off;
    logic [2:0] cfg_idx;
    logic       sel_ctrl, sel_stat, sel_num, sel_cfg, mapped;
    logic       wr_en, rd_en, ctrl_wr, start_req, abort_req, busy;
    logic       unused_addr;

    assign offs        = addr_i[7:0];
    assign cfg_off     = offs - 8'h10;
    assign cfg_idx     = cfg_off[4:2];
    assign sel_ctrl    = (offs == 8'h00);
    assign sel_stat    = (offs == 8'h04);
    assign sel_num     = (offs == 8'h08);
    assign sel_cfg     = (offs >= 8'h10) && (cfg_off[1:0] == 2'b00)
                         && (cfg_off[7:2] < 6'(NumLayers));
    assign mapped      = sel_ctrl | sel_stat | sel_num | sel_cfg;
    assign wr_en       = req_i & we_i;
    assign rd_en       = req_i & ~we_i;
    assign ctrl_wr     = wr_en & sel_ctrl;
    assign busy        = (state_q != IDLE);
    assign start_req   = ctrl_wr & wdata_i[0];
    assign abort_req   = ctrl_wr & wdata_i[1] & busy;
    assign unused_addr = ^addr_i[31:8];

    // Next-state logic: bus response, register writes and the layer sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        done_d    = done_q;
        err_d     = err_q;
        irq_en_d  = irq_en_q;
        num_d     = num_q;
        cfg_d     = cfg_q;
        layer_d   = layer_q;
        wdog_d    = wdog_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        rvalid_d  = req_i;
        rsp_err_d = req_i & ~mapped;
        rdata_d   = '0;

        if (rd_en) begin
            if (sel_ctrl)      rdata_d = {29'd0, irq_en_q, 2'b00};
            else if (sel_stat) rdata_d = {25'd0, layer_q, 1'b0, err_q, done_q, busy};
            else if (sel_num)  rdata_d = {28'd0, num_q};
            else begin
                for (int i = 0; i < NumLayers; i++)
                    if (sel_cfg && cfg_idx == 3'(i)) rdata_d = cfg_q[i];
            end
        end

        if (ctrl_wr) irq_en_d = wdata_i[2];
        if (wr_en && sel_num && !busy) num_d = wdata_i[3:0];
        for (int i = 0; i < NumLayers; i++)
            if (wr_en && sel_cfg && !busy && cfg_idx == 3'(i)) cfg_d[i] = wdata_i;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (num_q == 4'd0 || num_q > 4'(NumLayers)) begin
                        err_d = 1'b1;
                    end else begin
                        layer_d = 3'd0;
                        state_d = START;
                    end
                end
            end
            START: begin
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnn_done_i) begin
                    if ({1'b0, layer_q} == num_q - 4'd1) begin
                        state_d = NEXT;
                    end else begin
                        layer_d = layer_q + 3'd1;
                        state_d = START;
                    end
                end else if (wdog_q == WdLast) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            NEXT: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A software abort beats anything the sequencer decided this cycle.
        if (abort_req) begin
            state_d = IDLE;
            start_d = 1'b0;
            abort_d = 1'b1;
            done_d  = done_q;
            err_d   = err_q;
            layer_d = layer_q;
            wdog_d  = wdog_q;
        end

        // Write-one-to-clear wins over a same-cycle set.
        if (wr_en && sel_stat) begin
            if (wdata_i[1]) done_d = 1'b0;
            if (wdata_i[2]) err_d  = 1'b0;
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            num_q     <= '0;
            // NOTE: the descriptors are a handful of flops, not a RAM, so they are cleared with everything else.
            for (int i = 0; i < NumLayers; i++) cfg_q[i] <= '0;
            layer_q   <= '0;
            wdog_q    <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            num_q     <= num_d;
            cfg_q     <= cfg_d;
            layer_q   <= layer_d;
            wdog_q    <= wdog_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            rvalid_q  <= rvalid_d;
            rsp_err_q <= rsp_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Active descriptor presented to the engine while a sequence runs.
    always_comb begin
        cnn_cfg_o = '0;
        for (int i = 0; i < NumLayers; i++)
            if (busy && layer_q == 3'(i)) cnn_cfg_o = cfg_q[i];
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign err_o       = rsp_err_q;
    assign rdata_o     = rdata_q;
    assign cnn_start_o = start_q;
    assign cnn_abort_o = abort_q;
    assign cnn_layer_o = busy ? layer_q : 3'd0;
    assign irq_o       = (done_q | err_q) & irq_en_q;
endmodule
